// File: rtl/dot_seq.sv
// Dot-product sequencer: feeds one (a,b) term at a time to an external
// shift-add multiplier and accumulates the returned products into y_bo.
module dot_seq #(
   parameter int ACC_W = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [15:0]      a_bi,
   input  logic [7:0]       b_bi,
   input  logic             valid_i,
   input  logic             last_i,
   output logic             ready_o,
   output logic             mul_start_o,
   output logic [15:0]      mul_a_o,
   output logic [7:0]       mul_b_o,
   input  logic             mul_busy_i,
   input  logic [23:0]      mul_y_i,
   output logic [ACC_W-1:0] y_bo,
   output logic             done_o,
   output logic             ovf_o,
   output logic [CNT_W-1:0] cnt_o,
   output logic             busy_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_HI,
      S_WAIT_LO,
      S_DONE
   } state_t;

   state_t           state_q;
   logic [ACC_W-1:0] acc_q;
   logic [ACC_W-1:0] y_q;
   logic [CNT_W-1:0] cnt_q;
   logic             ovf_q;
   logic             done_q;
   logic             start_q;
   logic             last_q;
   logic             clr_pend_q;
   logic [15:0]      a_q;
   logic [7:0]       b_q;

   // One extra bit so the carry out of the accumulator is visible.
   logic [ACC_W:0]   sum_d;

   always_comb begin
      sum_d = {1'b0, acc_q} + {{(ACC_W-23){1'b0}}, mul_y_i};
   end

   // NOTE: all state below uses non-blocking assignments so every register
   // sees the pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         acc_q      <= '0;
         y_q        <= '0;
         cnt_q      <= '0;
         ovf_q      <= 1'b0;
         done_q     <= 1'b0;
         start_q    <= 1'b0;
         last_q     <= 1'b0;
         clr_pend_q <= 1'b0;
         a_q        <= '0;
         b_q        <= '0;
      end else begin
         done_q  <= 1'b0;
         start_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (valid_i) begin
                  a_q     <= a_bi;
                  b_q     <= b_bi;
                  last_q  <= last_i;
                  start_q <= 1'b1;
                  state_q <= S_ISSUE;
                  // Status of the finished vector stays visible until a new one begins.
                  if (clr_pend_q) begin
                     cnt_q      <= '0;
                     ovf_q      <= 1'b0;
                     clr_pend_q <= 1'b0;
                  end
               end
            end
            S_ISSUE: begin
               state_q <= S_WAIT_HI;
            end
            S_WAIT_HI: begin
               if (mul_busy_i) begin
                  state_q <= S_WAIT_LO;
               end
            end
            S_WAIT_LO: begin
               if (!mul_busy_i) begin
                  acc_q   <= sum_d[ACC_W-1:0];
                  cnt_q   <= cnt_q + CNT_W'(1);
                  ovf_q   <= ovf_q | sum_d[ACC_W];
                  state_q <= last_q ? S_DONE : S_IDLE;
               end
            end
            S_DONE: begin
               y_q        <= acc_q;
               done_q     <= 1'b1;
               acc_q      <= '0;
               clr_pend_q <= 1'b1;
               state_q    <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign ready_o     = (state_q == S_IDLE);
   assign busy_o      = (state_q != S_IDLE);
   assign mul_start_o = start_q;
   assign mul_a_o     = a_q;
   assign mul_b_o     = b_q;
   assign y_bo        = y_q;
   assign done_o      = done_q;
   assign ovf_o       = ovf_q;
   assign cnt_o       = cnt_q;

endmodule

// File: tb/tb_dot_seq.sv
// Self-checking bench for dot_seq: a behavioural multiplier, a vector-level
// reference model with a per-cycle compare process, and directed vectors.
module tb_dot_seq;

   localparam int ACC_W = 32;
   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst_i;
   logic [15:0]      a_bi;
   logic [7:0]       b_bi;
   logic             valid_i;
   logic             last_i;
   logic             ready_o;
   logic             mul_start_o;
   logic [15:0]      mul_a_o;
   logic [7:0]       mul_b_o;
   logic             mul_busy_i;
   logic [23:0]      mul_y_i;
   logic [ACC_W-1:0] y_bo;
   logic             done_o;
   logic             ovf_o;
   logic [CNT_W-1:0] cnt_o;
   logic             busy_o;

   always #5 clk = ~clk;

   dot_seq #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
      .clk_i      (clk),
      .rst_i      (rst_i),
      .a_bi       (a_bi),
      .b_bi       (b_bi),
      .valid_i    (valid_i),
      .last_i     (last_i),
      .ready_o    (ready_o),
      .mul_start_o(mul_start_o),
      .mul_a_o    (mul_a_o),
      .mul_b_o    (mul_b_o),
      .mul_busy_i (mul_busy_i),
      .mul_y_i    (mul_y_i),
      .y_bo       (y_bo),
      .done_o     (done_o),
      .ovf_o      (ovf_o),
      .cnt_o      (cnt_o),
      .busy_o     (busy_o)
   );

   // Multiplier: busy for mul_lat cycles after the start pulse; product
   // bus carries junk while busy so early sampling is caught.
   int          mul_lat = 8;
   int          mb_rem;
   logic        mb_busy;
   logic [23:0] mb_prod;

   always @(posedge clk) begin
      if (rst_i) begin
         mb_busy <= 1'b0;
         mb_rem  <= 0;
         mb_prod <= '0;
      end else if (mul_start_o) begin
         mb_busy <= 1'b1;
         mb_rem  <= mul_lat;
         mb_prod <= {8'h00, mul_a_o} * {16'h0000, mul_b_o};
      end else if (mb_busy) begin
         if (mb_rem == 1) mb_busy <= 1'b0;
         mb_rem <= mb_rem - 1;
      end
   end

   assign mul_busy_i = mb_busy;
   assign mul_y_i    = mb_busy ? 24'hA5A5A5 : mb_prod;

   typedef struct packed {
      logic [63:0] y;
      logic        ovf;
      logic [31:0] cnt;
   } vres_t;

   int          n_vec = 0;
   int          n_bad = 0;
   vres_t       exp_q[$];
   longint      cur_sum = 0;
   int          cur_cnt = 0;
   logic [63:0] held_y = '0;
   logic [15:0] last_a = '0;
   logic [7:0]  last_b = '0;
   int          n_hs = 0;
   int          n_starts = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Outputs are compared on the falling edge; the model then folds in
   // whatever the following rising edge will do (reset or handshake).
   task automatic monitor();
      logic [CNT_W-1:0] prev_cnt   = '0;
      logic             prev_start = 1'b0;
      int               cyc        = 0;
      int               acc_edge   = 0;
      longint           p;
      vres_t            v;
      forever begin
         @(negedge clk);
         cyc++;
         check("busy_vs_ready", busy_o, !ready_o);
         if (mb_busy) check("ready_while_mul_busy", ready_o, 0);
         if (done_o) begin
            if (exp_q.size() == 0) begin
               check("unexpected_done", done_o, 0);
            end else begin
               v = exp_q.pop_front();
               check("y_at_done", y_bo, v.y);
               check("cnt_at_done", cnt_o, v.cnt);
               check("ovf_at_done", ovf_o, v.ovf);
               held_y = v.y;
            end
         end else begin
            check("y_hold", y_bo, held_y);
         end
         if (mul_start_o) begin
            n_starts++;
            check("start_single_cycle", prev_start, 0);
            check("mul_a_latched", mul_a_o, last_a);
            check("mul_b_latched", mul_b_o, last_b);
         end
         if (cnt_o != prev_cnt && cnt_o != '0)
            check("term_latency", cyc - acc_edge, mul_lat + 2);
         prev_cnt   = cnt_o;
         prev_start = mul_start_o;

         if (rst_i) begin
            cur_sum = 0;
            cur_cnt = 0;
            held_y  = '0;
            exp_q.delete();
         end else if (valid_i && ready_o) begin
            p        = longint'(a_bi) * longint'(b_bi);
            cur_sum += p;
            cur_cnt++;
            last_a   = a_bi;
            last_b   = b_bi;
            acc_edge = cyc + 1;
            n_hs++;
            if (last_i) begin
               v.y   = 64'(cur_sum % (longint'(1) << ACC_W));
               v.ovf = (cur_sum >= (longint'(1) << ACC_W));
               v.cnt = 32'(cur_cnt % (1 << CNT_W));
               exp_q.push_back(v);
               cur_sum = 0;
               cur_cnt = 0;
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one term and return one step after the accepting edge.
   task automatic send(input logic [15:0] a, input logic [7:0] b, input logic l);
      int k = 0;
      valid_i = 1'b1;
      a_bi    = a;
      b_bi    = b;
      last_i  = l;
      @(negedge clk);
      while (!ready_o && k < 400) begin
         @(negedge clk);
         k++;
      end
      check("send_ready_seen", ready_o, 1);
      tick();
      valid_i = 1'b0;
      last_i  = 1'b0;
      a_bi    = '0;
      b_bi    = '0;
   endtask

   // Returns on the falling edge where done_o is seen (or the budget expires).
   task automatic wait_done();
      int k = 0;
      @(negedge clk);
      while (!done_o && k < 600) begin
         @(negedge clk);
         k++;
      end
      check("done_seen", done_o, 1);
   endtask

   task automatic check_pulse_end(input logic [63:0] y_exp);
      @(negedge clk);
      check("done_one_cycle", done_o, 0);
      check("y_after_done", y_bo, y_exp);
      tick();
   endtask

   initial begin
      int hs;
      int k;
      int st0;
      int hs0;
      rst_i   = 1'b1;
      valid_i = 1'b0;
      last_i  = 1'b0;
      a_bi    = '0;
      b_bi    = '0;
      tick();
      tick();
      fork
         monitor();
      join_none
      tick();
      rst_i = 1'b0;

      // Reset state
      @(negedge clk);
      check("rst_ready", ready_o, 1);
      check("rst_busy", busy_o, 0);
      check("rst_y", y_bo, 0);
      check("rst_cnt", cnt_o, 0);
      check("rst_ovf", ovf_o, 0);
      check("rst_done", done_o, 0);
      check("rst_start", mul_start_o, 0);
      check("rst_mul_a", mul_a_o, 0);
      check("rst_mul_b", mul_b_o, 0);
      tick();

      // Single term 3*5
      send(16'd3, 8'd5, 1'b1);
      wait_done();
      check("t1_y", y_bo, 15);
      check("t1_cnt", cnt_o, 1);
      check("t1_ovf", ovf_o, 0);
      check_pulse_end(15);

      // Three terms: 200 + 63 + 16711425
      send(16'd100, 8'd2, 1'b0);
      send(16'd7, 8'd9, 1'b0);
      send(16'd65535, 8'd255, 1'b1);
      wait_done();
      check("t2_y", y_bo, 16711688);
      check("t2_cnt", cnt_o, 3);
      check("t2_ovf", ovf_o, 0);
      check_pulse_end(16711688);

      // Zero operands still count as terms
      send(16'd0, 8'd0, 1'b0);
      send(16'd0, 8'd5, 1'b0);
      send(16'd4, 8'd0, 1'b1);
      wait_done();
      check("t3_y", y_bo, 0);
      check("t3_cnt", cnt_o, 3);
      check_pulse_end(0);

      // valid_i held high with data changing every cycle
      valid_i = 1'b1;
      hs = 0;
      k  = 0;
      while (hs < 3 && k < 300) begin
         a_bi = 16'($urandom);
         b_bi = 8'($urandom);
         if (ready_o) begin
            last_i = (hs == 2);
            hs++;
         end else begin
            last_i = 1'($urandom);
         end
         tick();
         k++;
      end
      valid_i = 1'b0;
      last_i  = 1'b0;
      wait_done();
      check("t4_cnt", cnt_o, 3);
      tick();

      // 258 maximal terms wrap a 32-bit accumulator once
      for (int i = 0; i < 258; i++) send(16'd65535, 8'd255, i == 257);
      wait_done();
      check("t5_y", y_bo, 16580354);
      check("t5_ovf", ovf_o, 1);
      check("t5_cnt", cnt_o, 258);
      tick();
      send(16'd1, 8'd1, 1'b1);
      check("t5_clr_cnt", cnt_o, 0);
      check("t5_clr_ovf", ovf_o, 0);
      check("t5_keep_y", y_bo, 16580354);
      wait_done();
      check("t5b_y", y_bo, 1);
      check("t5b_ovf", ovf_o, 0);
      check("t5b_cnt", cnt_o, 1);
      tick();

      // Reset while the second of three terms is waiting on the multiplier
      send(16'd10, 8'd10, 1'b0);
      send(16'd20, 8'd20, 1'b0);
      tick();
      tick();
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      @(negedge clk);
      check("t6_ready", ready_o, 1);
      check("t6_busy", busy_o, 0);
      check("t6_y", y_bo, 0);
      check("t6_cnt", cnt_o, 0);
      check("t6_ovf", ovf_o, 0);
      check("t6_done", done_o, 0);
      check("t6_start", mul_start_o, 0);
      check("t6_mul_a", mul_a_o, 0);
      check("t6_mul_b", mul_b_o, 0);
      tick();
      send(16'd2, 8'd2, 1'b1);
      wait_done();
      check("t6b_y", y_bo, 4);
      check("t6b_cnt", cnt_o, 1);
      tick();

      // Multiplier busy stretched to 20 cycles
      mul_lat = 20;
      st0 = n_starts;
      hs0 = n_hs;
      send(16'd300, 8'd7, 1'b0);
      send(16'd9, 8'd200, 1'b1);
      wait_done();
      check("t7_y", y_bo, 3900);
      check("t7_cnt", cnt_o, 2);
      check("t7_starts", n_starts - st0, 2);
      check("t7_handshakes", n_hs - hs0, 2);
      tick();
      mul_lat = 8;

      repeat (3) tick();
      check("pending_vectors", exp_q.size(), 0);
      check("starts_vs_handshakes", n_starts, n_hs);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/dot_seq.md
DOT_SEQ -- requirements
Module: dot_seq

Interface
REQ-001 SHALL have parameter ACC_W, default 32, giving the accumulator and result width in bits (legal range 24..48).
REQ-002 SHALL have parameter CNT_W, default 16, giving the width of the term counter.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all logic updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port a_bi, input, 16 bits: multiplicand of the offered term.
REQ-006 SHALL have port b_bi, input, 8 bits: multiplier of the offered term.
REQ-007 SHALL have port valid_i, input, 1 bit: a term is offered.
REQ-008 SHALL have port last_i, input, 1 bit: the offered term is the final term of the vector.
REQ-009 SHALL have port ready_o, output, 1 bit: the block can accept a term.
REQ-010 SHALL have port mul_start_o, output, 1 bit: start pulse to the shift-add multiplier.
REQ-011 SHALL have port mul_a_o, output, 16 bits: multiplicand driven to the multiplier.
REQ-012 SHALL have port mul_b_o, output, 8 bits: multiplier value driven to the multiplier.
REQ-013 SHALL have port mul_busy_i, input, 1 bit: multiplier busy flag.
REQ-014 SHALL have port mul_y_i, input, 24 bits: multiplier product.
REQ-015 SHALL have port y_bo, output, ACC_W bits: registered dot-product result.
REQ-016 SHALL have port done_o, output, 1 bit: one-cycle pulse marking a new y_bo.
REQ-017 SHALL have port ovf_o, output, 1 bit: sticky accumulator-wrap flag for the current vector.
REQ-018 SHALL have port cnt_o, output, CNT_W bits: number of terms accumulated in the current vector.
REQ-019 SHALL have port busy_o, output, 1 bit: high in every state except IDLE.

Function
REQ-020 SHALL implement states IDLE, ISSUE, WAIT_HI, WAIT_LO and DONE.
REQ-021 SHALL drive ready_o = 1 only in IDLE; a term is accepted when valid_i && ready_o, and no other input is sampled from the term interface.
REQ-022 SHALL, on acceptance, latch a_bi, b_bi and last_i into mul_a_o, mul_b_o and an internal last flag, and move from IDLE to ISSUE.
REQ-023 SHALL hold mul_a_o and mul_b_o stable from ISSUE until the return to IDLE or DONE.
REQ-024 SHALL assert mul_start_o for exactly the one ISSUE cycle, then move to WAIT_HI.
REQ-025 SHALL stay in WAIT_HI until mul_busy_i = 1, then move to WAIT_LO.
REQ-026 SHALL, in WAIT_LO, on the first cycle with mul_busy_i = 0:
  - add the zero-extended mul_y_i into the accumulator, wrapping modulo 2^ACC_W;
  - increment cnt_o, wrapping modulo 2^CNT_W;
  - set ovf_o if the addition carried out of ACC_W bits;
  - move to DONE if the last flag is set, otherwise to IDLE.
REQ-027 SHALL, in DONE, for one cycle:
  - load y_bo with the accumulator value;
  - pulse done_o;
  - clear the accumulator;
  - return to IDLE.
REQ-028 SHALL hold y_bo, ovf_o and cnt_o through DONE and into IDLE, so they are readable with done_o and after it.
REQ-029 SHALL clear ovf_o and cnt_o on the first term accepted after DONE, without changing y_bo.
REQ-030 SHALL give a per-term latency of 10 cycles from acceptance to the accumulate cycle, using a multiplier whose busy flag is high for 8 cycles after the start pulse.
REQ-031 SHALL not depend on the multiplier latency; correctness is set by the mul_busy_i handshake only.
REQ-032 SHALL treat a vector of one term with last_i = 1 as a complete vector.
REQ-033 SHALL accept zero operands normally; the term adds 0 and increments cnt_o.

Reset
REQ-034 SHALL, while rst_i = 1 on a clock edge, regardless of state (including mid-vector):
  - enter IDLE;
  - clear the accumulator, y_bo, cnt_o, ovf_o, done_o, mul_start_o, mul_a_o and mul_b_o;
  - discard any in-flight product.
REQ-035 SHALL drive ready_o = 1 on the first cycle after rst_i is released.

Verification
REQ-036 SHALL cover single term a = 3, b = 5, last = 1: y_bo = 15, done_o pulses once, cnt_o = 1, ovf_o = 0.
REQ-037 SHALL cover terms (100,2), (7,9), (65535,255) with last on the third: y_bo = 16711688, cnt_o = 3.
REQ-038 SHALL cover valid_i held high with changing data while busy: only values present when ready_o = 1 are accepted; the term count matches the number of handshakes.
REQ-039 SHALL cover 258 terms of (65535,255) with ACC_W = 32: y_bo = 16580354, ovf_o = 1, cnt_o = 258; a following vector (1,1) gives y_bo = 1, ovf_o = 0, cnt_o = 1.
REQ-040 SHALL cover rst_i pulsed in WAIT_LO of the second term of a 3-term vector: all outputs return to 0; a new single term (2,2) gives y_bo = 4.
REQ-041 SHALL cover mul_busy_i stretched to 20 cycles by the bench: the result is still correct and mul_start_o pulses exactly once per term.
